// File: rtl/conv_mem_responder_pkg.sv
// Shared widths, depths, bank-select codes and FSM states for the CONV memory responder.
package conv_mem_responder_pkg;
  localparam int DW        = 20;
  localparam int AW        = 12;
  localparam int IMG_DEPTH = 4096;
  localparam int L0_DEPTH  = 4096;
  localparam int L1_DEPTH  = 1024;

  localparam logic [2:0] CSEL_L0 = 3'd1;
  localparam logic [2:0] CSEL_L1 = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_KICK, ST_WAIT_HI, ST_WAIT_LO, ST_DUMP, ST_DONE
  } state_e;

  function automatic logic csel_valid(input logic [2:0] sel);
    return (sel == CSEL_L0) || (sel == CSEL_L1);
  endfunction
endpackage

// File: rtl/conv_mem_bank.sv
// Single-write-port memory with NR combinational read ports; out-of-range writes are
// dropped and out-of-range reads return 0. Reads see pre-edge contents (read-old).
module conv_mem_bank #(
  parameter int DEPTH = 1024,
  parameter int DW    = 20,
  parameter int AW    = 12,
  parameter int NR    = 1
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [AW-1:0]          waddr,
  input  logic [DW-1:0]          wdata,
  input  logic [NR-1:0][AW-1:0]  raddr,
  output logic [NR-1:0][DW-1:0]  rdata
);
  localparam int IW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          waddr_ok;

  assign waddr_ok = 32'(waddr) < 32'(DEPTH);

  always_ff @(posedge clk) begin
    if (wr_en && waddr_ok) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rdata[i] = (32'(raddr[i]) < 32'(DEPTH)) ? mem[raddr[i][IW-1:0]] : '0;
    end
  end
endmodule

// File: rtl/conv_mem_responder.sv
// Image / layer memory and run sequencer for the CONV engine: load image, kick, wait busy, dump L1.
// Optional CONV_MEM_CHECK_EN adds a sticky err output flagging illegal bank accesses and stray busy.
module conv_mem_responder
  import conv_mem_responder_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [DW-1:0] load_data,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic          dout_last,
`ifdef CONV_MEM_CHECK_EN
  output logic          err,
`endif
  output logic          done
);
  localparam logic [AW-1:0] IMG_LAST = AW'(IMG_DEPTH - 1);
  localparam logic [AW-1:0] L1_LAST  = AW'(L1_DEPTH - 1);

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [DW-1:0]         dout_data_q, dout_data_d;
  logic                  dout_last_q, dout_last_d;

  logic                  img_we;
  logic [AW-1:0]         img_waddr;
  logic [DW-1:0]         l0_rdata;
  logic [1:0][AW-1:0]    l1_raddr;
  logic [1:0][DW-1:0]    l1_rdata;
  logic [AW-1:0]         dump_raddr;
  logic                  dump_adv;

  assign load_ready = (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign img_we     = load_valid && load_ready;
  // A restart word accepted in DONE is image word 0.
  assign img_waddr  = (state_q == ST_DONE) ? '0 : cnt_q;

  // Prefetch the following word on a handshake so the dump streams one word per cycle.
  assign dump_adv   = dout_valid_q && dout_ready && !dout_last_q;
  assign dump_raddr = dump_adv ? idx_q + AW'(1) : idx_q;
  assign l1_raddr   = {dump_raddr, caddr_rd};

  conv_mem_bank #(.DEPTH(IMG_DEPTH), .DW(DW), .AW(AW), .NR(1)) u_img (
    .clk(clk), .wr_en(img_we), .waddr(img_waddr), .wdata(load_data),
    .raddr(iaddr), .rdata(idata)
  );

  conv_mem_bank #(.DEPTH(L0_DEPTH), .DW(DW), .AW(AW), .NR(1)) u_l0 (
    .clk(clk), .wr_en(cwr && (csel == CSEL_L0)), .waddr(caddr_wr), .wdata(cdata_wr),
    .raddr(caddr_rd), .rdata(l0_rdata)
  );

  conv_mem_bank #(.DEPTH(L1_DEPTH), .DW(DW), .AW(AW), .NR(2)) u_l1 (
    .clk(clk), .wr_en(cwr && (csel == CSEL_L1)), .waddr(caddr_wr), .wdata(cdata_wr),
    .raddr(l1_raddr), .rdata(l1_rdata)
  );

  always_comb begin
    cdata_rd = '0;
    if (crd) begin
      if (csel == CSEL_L0)      cdata_rd = l0_rdata;
      else if (csel == CSEL_L1) cdata_rd = l1_rdata[0];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    dout_last_d  = dout_last_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
      end
      ST_LOAD: begin
        if (load_valid) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == IMG_LAST) state_d = ST_KICK;
        end
      end
      ST_KICK:    if (busy) state_d = ST_WAIT_HI;
      ST_WAIT_HI: state_d = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (!busy) begin
          state_d = ST_DUMP;
          idx_d   = '0;
        end
      end
      ST_DUMP: begin
        if (!dout_valid_q) begin
          dout_valid_d = 1'b1;
          dout_data_d  = l1_rdata[1];
          dout_last_d  = (idx_q == L1_LAST);
        end else if (dout_ready) begin
          if (dout_last_q) begin
            state_d      = ST_DONE;
            dout_valid_d = 1'b0;
            dout_data_d  = '0;
            dout_last_d  = 1'b0;
          end else begin
            idx_d       = idx_q + AW'(1);
            dout_data_d = l1_rdata[1];
            dout_last_d = (dump_raddr == L1_LAST);
          end
        end
      end
      ST_DONE: begin
        if (load_valid) begin
          state_d = ST_LOAD;
          cnt_d   = AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_KICK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      ready_q      <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      ready_q      <= ready_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
      dout_last_q  <= dout_last_d;
    end
  end

  assign ready      = ready_q;
  assign dout_valid = dout_valid_q;
  assign dout_data  = dout_data_q;
  assign dout_last  = dout_last_q;
  assign done       = (state_q == ST_DONE);

`ifdef CONV_MEM_CHECK_EN
  logic err_q, err_d;
  logic wr_oor;

  always_comb begin
    wr_oor = (csel == CSEL_L1) ? (32'(caddr_wr) >= 32'(L1_DEPTH))
                               : (32'(caddr_wr) >= 32'(L0_DEPTH));
    err_d = err_q;
    if (state_d == ST_LOAD && state_q != ST_LOAD) err_d = 1'b0;
    if ((cwr && (!csel_valid(csel) || wr_oor)) ||
        (crd && !csel_valid(csel)) ||
        (busy && (state_q == ST_LOAD || state_q == ST_DONE))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif
endmodule
